// File: rtl/fib_interest_spi_tx_if.sv
// FIB-to-SPI byte interface: frame-start flag and the byte stream that follows it.
// The FIB side drives both signals; the SPI transmitter only reads them.
interface fib_interest_spi_tx_if;
  logic       FIB_to_SPI_data_flag;
  logic [7:0] data_FIB_to_SPI;

  modport master (output FIB_to_SPI_data_flag, output data_FIB_to_SPI);
  modport slave  (input  FIB_to_SPI_data_flag, input  data_FIB_to_SPI);
endinterface

// File: rtl/fib_interest_spi_tx.sv
// Buffers a 17-byte interest frame from the FIB and replays it as an SPI mode-0 master, MSB first.
// A guard period of CLK_DIV cycles with sclk low separates the last bit from the cs_n release.
module fib_interest_spi_tx #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned FRAME_BYTES = 17
) (
  input  logic                        clk,
  input  logic                        rst,
  fib_interest_spi_tx_if.slave        fib,
  output logic                        spi_sclk,
  output logic                        spi_mosi,
  output logic                        spi_cs_n,
  output logic                        tx_busy,
  output logic                        frame_done,
  output logic                        overflow
);

  localparam int unsigned FRAME_BITS = FRAME_BYTES * 8;
  localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [4:0]  BYTE_LAST  = 5'(FRAME_BYTES - 1);
  localparam logic [7:0]  BIT_FIRST  = 8'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_GUARD   = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic                    flag_q_r;
  logic                    start_s;
  logic [FRAME_BITS-1:0]   buf_r, buf_s;
  logic [4:0]              byte_cnt_r, byte_cnt_s;
  logic [7:0]              bit_cnt_r, bit_cnt_s, bit_prev_s;
  logic [7:0]              div_cnt_r, div_cnt_s;
  logic                    sclk_r, sclk_s;
  logic                    mosi_r, mosi_s;
  logic                    cs_n_r, cs_n_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic                    ovf_r, ovf_s;

  assign start_s = fib.FIB_to_SPI_data_flag & ~flag_q_r;

  // Next-state and next-output logic for the capture/shift/guard sequence.
  always_comb begin
    state_s    = state_r;
    buf_s      = buf_r;
    byte_cnt_s = byte_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    bit_prev_s = bit_cnt_r - 8'd1;
    div_cnt_s  = div_cnt_r;
    sclk_s     = sclk_r;
    mosi_s     = mosi_r;
    cs_n_s     = cs_n_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    // Any start while a frame is in flight, including the GUARD exit cycle, is dropped.
    ovf_s      = start_s & (state_r != ST_IDLE);

    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s    = ST_CAPTURE;
          byte_cnt_s = 5'd0;
          busy_s     = 1'b1;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        // Shift bytes in from the bottom so byte 0 ends up in the top byte.
        buf_s = {buf_r[FRAME_BITS-9:0], fib.data_FIB_to_SPI};
        if (byte_cnt_r == BYTE_LAST) begin
          state_s   = ST_SHIFT;
          cs_n_s    = 1'b0;
          sclk_s    = 1'b0;
          mosi_s    = buf_s[FRAME_BITS-1];
          bit_cnt_s = BIT_FIRST;
          div_cnt_s = 8'd0;
        end else begin
          byte_cnt_s = byte_cnt_r + 5'd1;
        end
      end
      ST_SHIFT: begin
        if (div_cnt_r == DIV_LAST) begin
          div_cnt_s = 8'd0;
          if (!sclk_r) begin
            sclk_s = 1'b1;
          end else begin
            sclk_s = 1'b0;
            if (bit_cnt_r == 8'd0) begin
              state_s = ST_GUARD;
            end else begin
              bit_cnt_s = bit_prev_s;
              mosi_s    = buf_r[bit_prev_s];
            end
          end
        end else begin
          div_cnt_s = div_cnt_r + 8'd1;
        end
      end
      ST_GUARD: begin
        if (div_cnt_r == DIV_LAST) begin
          state_s   = ST_IDLE;
          div_cnt_s = 8'd0;
          cs_n_s    = 1'b1;
          mosi_s    = 1'b0;
          busy_s    = 1'b0;
          done_s    = 1'b1;
        end else begin
          div_cnt_s = div_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cs_n_s  = 1'b1;
        sclk_s  = 1'b0;
        mosi_s  = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      flag_q_r   <= 1'b0;
      buf_r      <= {FRAME_BITS{1'b0}};
      byte_cnt_r <= 5'd0;
      bit_cnt_r  <= 8'd0;
      div_cnt_r  <= 8'd0;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
      cs_n_r     <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      flag_q_r   <= fib.FIB_to_SPI_data_flag;
      buf_r      <= buf_s;
      byte_cnt_r <= byte_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      div_cnt_r  <= div_cnt_s;
      sclk_r     <= sclk_s;
      mosi_r     <= mosi_s;
      cs_n_r     <= cs_n_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      ovf_r      <= ovf_s;
    end
  end

  assign spi_sclk   = sclk_r;
  assign spi_mosi   = mosi_r;
  assign spi_cs_n   = cs_n_r;
  assign tx_busy    = busy_r;
  assign frame_done = done_r;
  assign overflow   = ovf_r;

endmodule

// File: tb/tb_fib_interest_spi_tx.sv
// Bench for fib_interest_spi_tx: two instances (CLK_DIV=4 and CLK_DIV=1) share one FIB stream and are
// checked every cycle against a timeline model, plus literal checks on the sampled SPI stream.
module tb_fib_interest_spi_tx;

  localparam int DIV0 = 4;
  localparam int DIV1 = 1;

  typedef logic [7:0] frame_t [17];

  logic clk = 1'b0;
  logic rst = 1'b1;
  fib_interest_spi_tx_if bus();

  logic [1:0] sclk, mosi, cs_n, busy, done, ovf;

  fib_interest_spi_tx #(.CLK_DIV(DIV0)) dut0 (
    .clk(clk), .rst(rst), .fib(bus.slave),
    .spi_sclk(sclk[0]), .spi_mosi(mosi[0]), .spi_cs_n(cs_n[0]),
    .tx_busy(busy[0]), .frame_done(done[0]), .overflow(ovf[0])
  );

  fib_interest_spi_tx #(.CLK_DIV(DIV1)) dut1 (
    .clk(clk), .rst(rst), .fib(bus.slave),
    .spi_sclk(sclk[1]), .spi_mosi(mosi[1]), .spi_cs_n(cs_n[1]),
    .tx_busy(busy[1]), .frame_done(done[1]), .overflow(ovf[1])
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [135:0] got, input logic [135:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h required %0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // Outputs as {busy, cs_n, sclk, mosi, frame_done, overflow}, a pure function of cycles since start.
  logic [5:0] exp_v [2] = '{6'b010000, 6'b010000};
  int         m_act [2] = '{0, 0};
  int         m_rel [2] = '{0, 0};
  logic       m_pflag [2] = '{1'b0, 1'b0};
  frame_t     m_frame [2];

  task automatic model_step(input int d);
    int dv, e, i;
    logic st;
    logic [5:0] v;
    dv = (d == 0) ? DIV0 : DIV1;
    if (rst) begin
      m_act[d]   = 0;
      m_pflag[d] = 1'b0;
      exp_v[d]   = 6'b010000;
    end else begin
      st = bus.FIB_to_SPI_data_flag && !m_pflag[d];
      m_pflag[d] = bus.FIB_to_SPI_data_flag;
      if (m_act[d] != 0) begin
        m_rel[d]++;
        if (m_rel[d] <= 17) m_frame[d][m_rel[d]-1] = bus.data_FIB_to_SPI;
        e = m_rel[d] - 17;
        if (e < 0) begin
          v = 6'b110000;
        end else if (e < 272 * dv) begin
          i = e / (2 * dv);
          v = {1'b1, 1'b0, ((e % (2 * dv)) >= dv), m_frame[d][i/8][7-(i%8)], 2'b00};
        end else if (e < 273 * dv) begin
          v = {3'b100, m_frame[d][16][0], 2'b00};
        end else begin
          v = 6'b010010;
          m_act[d] = 0;
        end
        v[0] = st;
        exp_v[d] = v;
      end else if (st) begin
        m_act[d] = 1;
        m_rel[d] = 0;
        exp_v[d] = 6'b110000;
      end else begin
        exp_v[d] = 6'b010000;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step(0);
    model_step(1);
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    check("cycle_dut0", 136'({busy[0], cs_n[0], sclk[0], mosi[0], done[0], ovf[0]}), 136'(exp_v[0]));
    check("cycle_dut1", 136'({busy[1], cs_n[1], sclk[1], mosi[1], done[1], ovf[1]}), 136'(exp_v[1]));
  end

  // ---------------- SPI-side monitor ----------------
  logic [135:0] sh [2]        = '{136'd0, 136'd0};
  logic [135:0] last_bits [2] = '{136'd0, 136'd0};
  int rises [2] = '{0, 0};
  int lowc [2] = '{0, 0};
  int last_rises [2] = '{0, 0};
  int last_low [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int ovf_cnt [2] = '{0, 0};
  logic p_sclk [2] = '{1'b0, 1'b0};
  logic p_cs [2] = '{1'b1, 1'b1};

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!cs_n[d]) begin
        lowc[d]++;
        if (sclk[d] && !p_sclk[d]) begin
          rises[d]++;
          sh[d] = {sh[d][134:0], mosi[d]};
        end
      end
      if (cs_n[d] && !p_cs[d]) begin
        last_bits[d]  = sh[d];
        last_rises[d] = rises[d];
        last_low[d]   = lowc[d];
        sh[d] = 136'd0; rises[d] = 0; lowc[d] = 0;
      end
      if (done[d]) done_cnt[d]++;
      if (ovf[d]) ovf_cnt[d]++;
      p_sclk[d] = sclk[d];
      p_cs[d]   = cs_n[d];
    end
  end

  // ---------------- stimulus helpers ----------------
  int s_done [2];
  int s_ovf [2];

  task automatic snap();
    for (int d = 0; d < 2; d++) begin
      s_done[d] = done_cnt[d];
      s_ovf[d]  = ovf_cnt[d];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.data_FIB_to_SPI = 8'($urandom);
    end
  endtask

  // Caller is positioned at a negedge; the start is seen at the following posedge.
  task automatic start_frame(input frame_t f, input bit hold);
    bus.FIB_to_SPI_data_flag = 1'b1;
    bus.data_FIB_to_SPI = 8'($urandom);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus.data_FIB_to_SPI = f[i];
      if (!hold) bus.FIB_to_SPI_data_flag = 1'b0;
    end
  endtask

  task automatic pulse_flag();
    @(negedge clk);
    bus.FIB_to_SPI_data_flag = 1'b0;
    @(negedge clk);
    bus.FIB_to_SPI_data_flag = 1'b1;
    @(negedge clk);
    bus.FIB_to_SPI_data_flag = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    while (!done[d] && n < 4000) begin
      @(negedge clk);
      bus.data_FIB_to_SPI = 8'($urandom);
      n++;
    end
    check("frame_done_seen", 136'(done[d]), 136'd1);
  endtask

  function automatic logic [135:0] pack(input frame_t f);
    logic [135:0] v;
    v = 136'd0;
    for (int i = 0; i < 17; i++) v = {v[127:0], f[i]};
    return v;
  endfunction

  frame_t basic = '{8'h15, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                    8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
  logic [135:0] basic_lit = 136'h15_0102030405060708_A1A2A3A4A5A6A7A8;

  initial begin
    frame_t fa, fb;
    bus.FIB_to_SPI_data_flag = 1'b0;
    bus.data_FIB_to_SPI = 8'h00;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_outputs", 136'({busy[0], cs_n[0], sclk[0], mosi[0], done[0], ovf[0]}), 136'(6'b010000));
    rst = 1'b0;
    idle(5);

    // Basic frame on both divisors.
    snap();
    @(negedge clk);
    start_frame(basic, 1'b0);
    wait_done(0);
    idle(5);
    check("basic_stream_div4", last_bits[0], basic_lit);
    check("basic_rises_div4", 136'(last_rises[0]), 136'd136);
    check("basic_cslow_div4", 136'(last_low[0]), 136'd1092);
    check("basic_done_div4", 136'(done_cnt[0] - s_done[0]), 136'd1);
    check("basic_stream_div1", last_bits[1], basic_lit);
    check("basic_rises_div1", 136'(last_rises[1]), 136'd136);
    check("basic_cslow_div1", 136'(last_low[1]), 136'd273);
    check("basic_done_div1", 136'(done_cnt[1] - s_done[1]), 136'd1);
    check("basic_no_ovf", 136'(ovf_cnt[0] - s_ovf[0]), 136'd0);

    // Second start about 100 cycles into the frame is dropped.
    snap();
    @(negedge clk);
    start_frame(basic, 1'b0);
    idle(80);
    pulse_flag();
    wait_done(0);
    idle(5);
    check("ovf_count_div4", 136'(ovf_cnt[0] - s_ovf[0]), 136'd1);
    check("ovf_count_div1", 136'(ovf_cnt[1] - s_ovf[1]), 136'd1);
    check("ovf_done_div4", 136'(done_cnt[0] - s_done[0]), 136'd1);
    check("ovf_stream_div4", last_bits[0], basic_lit);

    // Flag held high across the whole frame never retriggers.
    snap();
    @(negedge clk);
    start_frame(basic, 1'b1);
    wait_done(0);
    idle(50);
    bus.FIB_to_SPI_data_flag = 1'b0;
    idle(5);
    check("held_no_ovf_div4", 136'(ovf_cnt[0] - s_ovf[0]), 136'd0);
    check("held_no_ovf_div1", 136'(ovf_cnt[1] - s_ovf[1]), 136'd0);
    check("held_done_div4", 136'(done_cnt[0] - s_done[0]), 136'd1);
    check("held_done_div1", 136'(done_cnt[1] - s_done[1]), 136'd1);

    // Back-to-back: second start on the frame_done cycle is accepted.
    for (int i = 0; i < 17; i++) begin
      fa[i] = 8'($urandom);
      fb[i] = 8'($urandom);
    end
    snap();
    @(negedge clk);
    start_frame(fa, 1'b0);
    wait_done(0);
    start_frame(fb, 1'b0);
    wait_done(0);
    idle(5);
    check("b2b_no_ovf", 136'(ovf_cnt[0] - s_ovf[0]), 136'd0);
    check("b2b_done", 136'(done_cnt[0] - s_done[0]), 136'd2);
    check("b2b_stream", last_bits[0], pack(fb));

    // Start on the GUARD exit edge counts as overflow (CLK_DIV=4 instance).
    snap();
    @(negedge clk);
    start_frame(basic, 1'b0);
    idle(1109 - 17);
    bus.FIB_to_SPI_data_flag = 1'b1;
    @(negedge clk);
    bus.FIB_to_SPI_data_flag = 1'b0;
    idle(400);
    check("guard_exit_ovf", 136'(ovf_cnt[0] - s_ovf[0]), 136'd1);
    check("guard_exit_done", 136'(done_cnt[0] - s_done[0]), 136'd1);
    check("guard_exit_idle", 136'(busy[0]), 136'd0);
    check("guard_exit_div1_done", 136'(done_cnt[1] - s_done[1]), 136'd2);

    // Reset mid-SHIFT aborts without frame_done, then a clean frame follows.
    @(negedge clk);
    start_frame(basic, 1'b0);
    idle(300);
    snap();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", 136'({busy[0], cs_n[0], sclk[0], mosi[0], done[0], ovf[0]}), 136'(6'b010000));
    idle(2);
    rst = 1'b0;
    idle(20);
    check("rst_mid_no_done", 136'(done_cnt[0] - s_done[0]), 136'd0);
    @(negedge clk);
    start_frame(basic, 1'b0);
    wait_done(0);
    idle(5);
    check("rst_after_stream", last_bits[0], basic_lit);
    check("rst_after_cslow", 136'(last_low[0]), 136'd1092);

    // Randomized frames, extra starts and occasional resets; checked by the per-cycle model.
    for (int it = 0; it < 10; it++) begin
      frame_t f;
      bit hold;
      for (int j = 0; j < 17; j++) f[j] = 8'($urandom);
      hold = 1'($urandom_range(0, 1));
      @(negedge clk);
      start_frame(f, hold);
      if ($urandom_range(0, 7) == 0) begin
        idle(int'($urandom_range(1, 1000)));
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        bus.FIB_to_SPI_data_flag = 1'b0;
        idle(5);
      end else begin
        repeat ($urandom_range(0, 2)) begin
          idle(int'($urandom_range(10, 400)));
          pulse_flag();
        end
        wait_done(0);
        bus.FIB_to_SPI_data_flag = 1'b0;
        idle(int'($urandom_range(1, 20)));
      end
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
